// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forwarding selects,
// multi-cycle FSM states and the forwarding priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // The M stage holds the younger result, so it takes priority over W.
  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/mc_busy_fsm.sv
// Holds the E stage for MC_LAT cycles when a multi-cycle op (MUL/DIV) starts.
// mc_stall is combinational; mc_busy is decoded directly from the state register.
module mc_busy_fsm
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic multi_start,
  output logic mc_stall,
  output logic mc_busy
);

  localparam int CNT_BITS = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam int LOAD_VAL = (MC_LAT > 1) ? (MC_LAT - 2) : 0;

  mc_state_t           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        if (multi_start && (MC_LAT > 1)) begin
          state_d  = MC_BUSY;
          cnt_d    = CNT_BITS'(LOAD_VAL);
          mc_stall = 1'b1;
        end
      end
      MC_BUSY: begin
        // The final BUSY cycle releases E; a new start is only seen back in IDLE.
        mc_stall = (cnt_q != '0);
        if (cnt_q == '0) state_d = MC_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mc_busy = (state_q == MC_BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipe: operand forwarding, load-use and multi-cycle
// stalls, branch/PC-write flushes and a saturating stall-cycle perf counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   MatchE_M,
  input  logic [NSRC-1:0]   MatchE_W,
  input  logic              MatchD_E,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MultiStartE,
  input  logic              BranchTakenD,
  input  logic              PCSrcW,
  input  logic              PCWrPendingF,
  output logic [2*NSRC-1:0] ForwardE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MCBusy,
  output logic [CNT_W-1:0]  StallCycles
);

  logic             mc_stall;
  logic             ld_stall;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  mc_busy_fsm #(
    .MC_LAT(MC_LAT)
  ) u_mc_fsm (
    .clk        (clk),
    .reset      (reset),
    .multi_start(MultiStartE),
    .mc_stall   (mc_stall),
    .mc_busy    (MCBusy)
  );

  always_comb begin
    ForwardE = '0;
    for (int i = 0; i < NSRC; i++) begin
      ForwardE[2*i +: 2] = fwd_sel(MatchE_M[i] & RegWriteM, MatchE_W[i] & RegWriteW);
    end
  end

  // A held E stage keeps the load in place, so the load-use bubble waits for release.
  assign ld_stall = MatchD_E & MemtoRegE & ~mc_stall;

  assign StallE = mc_stall;
  assign FlushM = mc_stall;
  assign StallD = ld_stall | mc_stall;
  assign StallF = StallD | PCWrPendingF;
  assign FlushE = ld_stall;
  assign FlushD = PCSrcW | ((PCWrPendingF | BranchTakenD) & ~StallD);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (StallF && (stall_cycles_q != {CNT_W{1'b1}})) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: a driver pushes model predictions per cycle,
// a monitor pops and compares them against the DUT outputs at the falling edge.
module tb_hazard_unit_mc;

  localparam int NSRC   = 3;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            rst;
    logic [NSRC-1:0] me_m;
    logic [NSRC-1:0] me_w;
    logic            md_e;
    logic            rwm;
    logic            rww;
    logic            mtr;
    logic            ms;
    logic            bt;
    logic            pcs;
    logic            pcw;
  } stim_t;

  typedef struct packed {
    logic [2*NSRC-1:0] fwd;
    logic [5:0]        ctl;   // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    logic              busy;
    logic [CNT_W-1:0]  cycles;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NSRC-1:0]   match_e_m = '0;
  logic [NSRC-1:0]   match_e_w = '0;
  logic              match_d_e = 1'b0;
  logic              reg_write_m = 1'b0;
  logic              reg_write_w = 1'b0;
  logic              mem_to_reg_e = 1'b0;
  logic              multi_start_e = 1'b0;
  logic              branch_taken_d = 1'b0;
  logic              pc_src_w = 1'b0;
  logic              pc_wr_pending_f = 1'b0;
  logic [2*NSRC-1:0] forward_e;
  logic              stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
  logic [CNT_W-1:0]  stall_cycles;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  int mc_left   = 0;
  int stall_cnt = 0;

  hazard_unit_mc #(
    .NSRC  (NSRC),
    .MC_LAT(MC_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MatchE_M    (match_e_m),
    .MatchE_W    (match_e_w),
    .MatchD_E    (match_d_e),
    .RegWriteM   (reg_write_m),
    .RegWriteW   (reg_write_w),
    .MemtoRegE   (mem_to_reg_e),
    .MultiStartE (multi_start_e),
    .BranchTakenD(branch_taken_d),
    .PCSrcW      (pc_src_w),
    .PCWrPendingF(pc_wr_pending_f),
    .ForwardE    (forward_e),
    .StallF      (stall_f),
    .StallD      (stall_d),
    .StallE      (stall_e),
    .FlushD      (flush_d),
    .FlushE      (flush_e),
    .FlushM      (flush_m),
    .MCBusy      (mc_busy),
    .StallCycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // mc_left counts cycles E remains occupied after the current one.
  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    logic mc_st, ld, sd, sf;
    @(posedge clk);
    #1;
    reset           = s.rst;
    match_e_m       = s.me_m;
    match_e_w       = s.me_w;
    match_d_e       = s.md_e;
    reg_write_m     = s.rwm;
    reg_write_w     = s.rww;
    mem_to_reg_e    = s.mtr;
    multi_start_e   = s.ms;
    branch_taken_d  = s.bt;
    pc_src_w        = s.pcs;
    pc_wr_pending_f = s.pcw;

    for (int i = 0; i < NSRC; i++) begin
      if (s.me_m[i] && s.rwm)      e.fwd[2*i +: 2] = 2'b10;
      else if (s.me_w[i] && s.rww) e.fwd[2*i +: 2] = 2'b01;
      else                         e.fwd[2*i +: 2] = 2'b00;
    end
    mc_st = (mc_left == 0) ? (s.ms && (MC_LAT > 1)) : (mc_left > 1);
    ld    = s.md_e && s.mtr && !mc_st;
    sd    = ld || mc_st;
    sf    = sd || s.pcw;
    e.ctl    = {sf, sd, mc_st, s.pcs || ((s.pcw || s.bt) && !sd), ld, mc_st};
    e.busy   = (mc_left > 0);
    e.cycles = CNT_W'(stall_cnt);
    exp_q.push_back(e);

    if (s.rst) begin
      mc_left   = 0;
      stall_cnt = 0;
    end else begin
      if (mc_left == 0) begin
        if (s.ms && (MC_LAT > 1)) mc_left = MC_LAT - 1;
      end else begin
        mc_left = mc_left - 1;
      end
      if (sf && stall_cnt < CNT_MAX) stall_cnt = stall_cnt + 1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("ForwardE", 32'(forward_e), 32'(e.fwd));
        check_output("stall_flush", 32'({stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}), 32'(e.ctl));
        check_output("MCBusy", 32'(mc_busy), 32'(e.busy));
        check_output("StallCycles", 32'(stall_cycles), 32'(e.cycles));
      end
    end
  end

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim(input int rst_odds);
    stim_t s;
    s.rst  = ($urandom_range(rst_odds - 1) == 0);
    s.me_m = NSRC'($urandom);
    s.me_w = NSRC'($urandom);
    s.md_e = ($urandom_range(2) == 0);
    s.rwm  = $urandom_range(1);
    s.rww  = $urandom_range(1);
    s.mtr  = ($urandom_range(2) == 0);
    s.ms   = ($urandom_range(5) == 0);
    s.bt   = ($urandom_range(3) == 0);
    s.pcs  = ($urandom_range(7) == 0);
    s.pcw  = ($urandom_range(4) == 0);
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    s = idle_stim();
    s.rst = 1'b1;
    repeat (2) apply_stimulus(s);

    s = idle_stim();
    s.me_m = 3'b001; s.me_w = 3'b011; s.rwm = 1'b1; s.rww = 1'b1;
    apply_stimulus(s);

    s = idle_stim();
    s.md_e = 1'b1; s.mtr = 1'b1;
    apply_stimulus(s);
    apply_stimulus(idle_stim());

    s = idle_stim();
    s.ms = 1'b1;
    apply_stimulus(s);
    repeat (4) apply_stimulus(idle_stim());

    apply_stimulus(s);
    s = idle_stim();
    s.md_e = 1'b1; s.mtr = 1'b1;
    repeat (5) apply_stimulus(s);

    s.bt = 1'b1;
    apply_stimulus(s);
    s.bt = 1'b0; s.pcs = 1'b1;
    apply_stimulus(s);

    s = idle_stim();
    s.ms = 1'b1;
    apply_stimulus(s);
    s.ms = 1'b0; s.rst = 1'b1;
    apply_stimulus(s);
    repeat (3) apply_stimulus(idle_stim());

    s = idle_stim();
    s.ms = 1'b1;
    repeat (10) apply_stimulus(s);

    repeat (400) apply_stimulus(rand_stim(50));

    s = idle_stim();
    s.rst = 1'b1;
    apply_stimulus(s);
    s = idle_stim();
    s.pcw = 1'b1;
    repeat (CNT_MAX + 5) apply_stimulus(s);
    repeat (3) apply_stimulus(idle_stim());

    repeat (300) apply_stimulus(rand_stim(1000));

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
